imem_ram: RTL and testbench

Writable, handshaked instruction memory that replaces the fixed-content instruction ROM in the core's fetch path. Program images are loaded word by word through a program port while the block is in BOOT. Once software signals `boot_done`, the block serves fetches with one-cycle synchronous read latency over a valid/ready interface. Misaligned and out-of-range fetches return an error flag and a NOP instead of wrapping.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_bank.sv | 84 ++++++++
 rtl/imem_ram.sv | 171 +++++++++++++++++
 tb/tb_imem_ram.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : imem_pkg                                               |
// | Description : Shared types and constants for the writable            |
// |               instruction memory (imem_ram / imem_bank).             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package imem_pkg;

  // RV32I canonical NOP (addi x0, x0, 0), returned on any faulted fetch
  localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

  localparam int IMEM_DEPTH_DEFAULT = 4096;

  // BOOT accepts program writes; RUN serves fetches and is terminal
  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } imem_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } imem_rsp_t;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : imem_bank                                              |
// | Description : 1R1W synchronous word array with byte-enable writes    |
// |               and a registered read port. Kept separate so it can    |
// |               be replaced by an SRAM macro. When IMEM_PARITY_EN is   |
// |               defined, one even-parity bit per byte is stored and    |
// |               the read port also returns a registered parity-error.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module imem_bank #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  output logic          rperr
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Byte-masked write; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Array read ahead of the output register
  always_comb begin
    rdata_d = mem[raddr];
  end

  // Read register only advances on a read so the data holds under stall
  always_ff @(posedge clk) begin
    if (re) rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

`ifdef IMEM_PARITY_EN
  logic [3:0] par [DEPTH];
  logic       rperr_d;
  logic       rperr_q;

  // Parity bit per byte equals the XOR of that byte (even parity overall)
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) par[waddr][i] <= ^wdata[8*i +: 8];
      end
    end
  end

  // Any byte whose data plus parity bit is odd flags the word as corrupt
  always_comb begin
    rperr_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rperr_d = rperr_d | (^{rdata_d[8*i +: 8], par[raddr][i]});
    end
  end

  // Error flag travels with the read data it describes
  always_ff @(posedge clk) begin
    if (re) rperr_q <= rperr_d;
  end

  assign rperr = rperr_q;
`else
  assign rperr = 1'b0;
`endif

endmodule : imem_bank
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : imem_ram                                               |
// | Description : Writable, handshaked instruction memory. Loaded word   |
// |               by word in BOOT, then serves fetches in RUN with one   |
// |               cycle of latency over valid/ready. Misaligned or       |
// |               out-of-range fetches return NOP with an error flag.    |
// |               Optional macro IMEM_PARITY_EN adds per-byte parity     |
// |               checking and the perr_sticky flag.                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module imem_ram
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_wdata,
  input  logic [3:0]  prog_be,
  input  logic        boot_done,
  output logic        prog_err,
  output logic [15:0] load_words,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  output logic        perr_sticky
);

  localparam int AW = $clog2(DEPTH);

  imem_state_e state_q, state_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_live_q, rsp_live_d;   // response is a good word read from the bank
  logic        rsp_bad_q, rsp_bad_d;     // response is an address fault
  logic        prog_err_q, prog_err_d;
  logic [15:0] load_words_q, load_words_d;

  logic        wr_in_range;
  logic        wr_ok;
  logic        fetch_in_range;
  logic        fetch_aligned;
  logic        fetch_acc;
  logic        fetch_good;
  logic [31:0] bank_rdata;
  logic        bank_rperr;
  logic        perr_hit;
  imem_rsp_t   rsp_w;

  // Byte-offset bits of the write address carry no meaning
  logic unused_prog_addr_lsb;
  assign unused_prog_addr_lsb = ^prog_addr[1:0];

  // Address qualification: word index must fall inside the array
  assign wr_in_range    = (prog_addr[31:AW+2] == '0);
  assign wr_ok          = prog_we && (state_q == BOOT) && wr_in_range;
  assign fetch_in_range = (req_addr[31:AW+2] == '0);
  assign fetch_aligned  = (req_addr[1:0] == 2'b00);

  assign req_ready  = (state_q == RUN) && (!rsp_valid_q || rsp_ready);
  assign fetch_acc  = req_valid && req_ready;
  assign fetch_good = fetch_acc && fetch_aligned && fetch_in_range;

  imem_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (prog_addr[AW+1:2]),
    .wdata (prog_wdata),
    .be    (prog_be),
    .re    (fetch_good),
    .raddr (req_addr[AW+1:2]),
    .rdata (bank_rdata),
    .rperr (bank_rperr)
  );

  // BOOT -> RUN on boot_done; RUN only leaves through reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (boot_done) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Response slot, write-drop pulse and saturating load counter
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_live_d   = rsp_live_q;
    rsp_bad_d    = rsp_bad_q;
    load_words_d = load_words_q;
    prog_err_d   = prog_we && !wr_ok;
    if (fetch_acc) begin
      rsp_valid_d = 1'b1;
      rsp_live_d  = fetch_good;
      rsp_bad_d   = !fetch_good;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (wr_ok && (load_words_q != 16'hFFFF)) begin
      load_words_d = load_words_q + 16'd1;
    end
  end

  // Control state with asynchronous reset; an in-flight response is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      rsp_valid_q  <= 1'b0;
      rsp_live_q   <= 1'b0;
      rsp_bad_q    <= 1'b0;
      prog_err_q   <= 1'b0;
      load_words_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_live_q   <= rsp_live_d;
      rsp_bad_q    <= rsp_bad_d;
      prog_err_q   <= prog_err_d;
      load_words_q <= load_words_d;
    end
  end

  // Parity fault only counts when the response really came from the bank
  assign perr_hit = rsp_live_q && bank_rperr;

`ifdef IMEM_PARITY_EN
  logic perr_sticky_q, perr_sticky_d;

  // Sticky flag latches the first corrupt response until reset
  always_comb begin
    perr_sticky_d = perr_sticky_q | perr_hit;
  end

  // Sticky flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_sticky_q <= 1'b0;
    else        perr_sticky_q <= perr_sticky_d;
  end

  // Visible from the response edge onward
  assign perr_sticky = perr_sticky_q | perr_hit;
`else
  assign perr_sticky = 1'b0;
`endif

  // Faulted or reset responses present the NOP; good ones present bank data
  always_comb begin
    rsp_w.inst = IMEM_NOP;
    rsp_w.err  = rsp_bad_q | perr_hit;
    if (rsp_live_q && !bank_rperr) rsp_w.inst = bank_rdata;
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_inst   = rsp_w.inst;
  assign rsp_err    = rsp_w.err;
  assign prog_err   = prog_err_q;
  assign load_words = load_words_q;

endmodule : imem_ram
`default_nettype wire

// File: tb/tb_imem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_imem_ram                                            |
// | Description : Directed self-checking bench for imem_ram. Parity      |
// |               checks are compiled in with IMEM_PARITY_EN.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_imem_ram;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic [3:0]  prog_be;
  logic        boot_done;
  logic        prog_err;
  logic [15:0] load_words;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        perr_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  imem_ram #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_wdata  (prog_wdata),
    .prog_be     (prog_be),
    .boot_done   (boot_done),
    .prog_err    (prog_err),
    .load_words  (load_words),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_inst    (rsp_inst),
    .rsp_err     (rsp_err),
    .perr_sticky (perr_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One program write; returns at the negedge after the write edge
  task automatic prog(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d; prog_be = be;
    @(negedge clk);
    prog_we = 1'b0; prog_be = 4'h0;
  endtask

  // One fetch with rsp_ready high; checks the response one cycle later
  task automatic fetch(input string tag, input logic [31:0] a,
                       input logic [31:0] exp_inst, input logic exp_err);
    req_valid = 1'b1; req_addr = a;
    #1 check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, "_vld"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_inst"}, rsp_inst, exp_inst);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0; prog_be = '0;
    boot_done = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_vld",   {31'd0, rsp_valid}, 32'd0);
    check("rst_inst",  rsp_inst, NOP);
    check("rst_err",   {31'd0, rsp_err}, 32'd0);
    check("rst_perr",  {31'd0, prog_err}, 32'd0);
    check("rst_lw",    {16'd0, load_words}, 32'd0);
    check("rst_stk",   {31'd0, perr_sticky}, 32'd0);
    check("rst_rdy",   {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Program image in BOOT
    prog(32'h0, 32'hDEADBEEF, 4'hF);
    prog(32'h4, 32'h00A00093, 4'hF);
    prog(32'h8, 32'hFFFFFFFF, 4'hF);
    prog(32'h8, 32'h12345678, 4'b0101);
    prog(32'hC, 32'h11111111, 4'hF);
    check("boot_noerr", {31'd0, prog_err}, 32'd0);
    prog(32'h4 * DEPTH, 32'hAAAAAAAA, 4'hF);
    check("oor_wr_perr", {31'd0, prog_err}, 32'd1);
    @(negedge clk);
    check("perr_pulse", {31'd0, prog_err}, 32'd0);
    check("lw_count", {16'd0, load_words}, 32'd5);

    // Fetch held off in BOOT, no error raised
    req_valid = 1'b1; req_addr = 32'h0;
    #1 check("boot_rdy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("boot_novld", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    boot_done = 1'b1;
    @(negedge clk);
    boot_done = 1'b0;

    fetch("f0",   32'h0,         32'hDEADBEEF, 1'b0);
    fetch("f4",   32'h4,         32'h00A00093, 1'b0);
    fetch("fbe",  32'h8,         32'hFF34FF78, 1'b0);
    fetch("fmis", 32'h2,         NOP,          1'b1);
    fetch("foor", 32'h4 * DEPTH, NOP,          1'b1);

    // Write attempted in RUN is dropped
    prog(32'hC, 32'h00000000, 4'hF);
    check("run_wr_perr", {31'd0, prog_err}, 32'd1);
    check("run_wr_lw", {16'd0, load_words}, 32'd5);
    fetch("fold", 32'hC, 32'h11111111, 1'b0);

    // Back-to-back fetches
    req_valid = 1'b1; req_addr = 32'h0;
    @(negedge clk);
    check("b2b_0", rsp_inst, 32'hDEADBEEF);
    req_addr = 32'h4;
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_1", rsp_inst, 32'h00A00093);
    check("b2b_1v", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    check("b2b_idle", {31'd0, rsp_valid}, 32'd0);

    // Backpressure
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0;
    @(negedge clk);
    check("bp_first", rsp_inst, 32'hDEADBEEF);
    req_addr = 32'h4;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_rdy", {31'd0, req_ready}, 32'd0);
      check("bp_hold", rsp_inst, 32'hDEADBEEF);
      check("bp_vld", {31'd0, rsp_valid}, 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 check("bp_release_rdy", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("bp_next", rsp_inst, 32'h00A00093);
    check("bp_next_v", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    check("bp_nodup", {31'd0, rsp_valid}, 32'd0);

`ifdef IMEM_PARITY_EN
    dut.u_bank.mem[0] = dut.u_bank.mem[0] ^ 32'h0000_0001;
    fetch("fpar", 32'h0, NOP, 1'b1);
    check("par_stk", {31'd0, perr_sticky}, 32'd1);
    fetch("fclean", 32'h4, 32'h00A00093, 1'b0);
    check("par_stk_hold", {31'd0, perr_sticky}, 32'd1);
`else
    check("no_par_stk", {31'd0, perr_sticky}, 32'd0);
`endif

    // Reset while a response is pending
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
    @(negedge clk);
    req_valid = 1'b0;
    check("mr_pre_vld", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_vld",  {31'd0, rsp_valid}, 32'd0);
    check("mr_inst", rsp_inst, NOP);
    check("mr_err",  {31'd0, rsp_err}, 32'd0);
    check("mr_rdy",  {31'd0, req_ready}, 32'd0);
    check("mr_lw",   {16'd0, load_words}, 32'd0);
    check("mr_stk",  {31'd0, perr_sticky}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h8;
    #1 check("mr_boot_rdy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    boot_done = 1'b1;
    @(negedge clk);
    boot_done = 1'b0;
    fetch("fkeep", 32'h8, 32'hFF34FF78, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_imem_ram
`default_nettype wire
